// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin CPU/DMA arbiter in front of a single-port sync memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CpuReq,
  input  logic        CpuWE,
  input  logic [15:0] CpuAddr,
  input  logic [15:0] CpuWData,
  output logic [15:0] CpuRData,
  output logic        Perform,
  input  logic        DmaReq,
  input  logic        DmaWE,
  input  logic [15:0] DmaAddr,
  input  logic [15:0] DmaWData,
  output logic [15:0] DmaRData,
  output logic        DmaAck,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  output logic        MemWE,
  input  logic [15:0] MemRData,
  output logic [7:0]  StallCnt
);

  localparam logic [4:0] c_IDLE    = 5'b00001;
  localparam logic [4:0] c_C_ISSUE = 5'b00010;
  localparam logic [4:0] c_C_DONE  = 5'b00100;
  localparam logic [4:0] c_D_ISSUE = 5'b01000;
  localparam logic [4:0] c_D_DONE  = 5'b10000;
  localparam logic [7:0] c_STALL_MAX = 8'hFF;

  logic [4:0]  r_state;
  logic [4:0]  w_next_state;
  logic        r_last_dma;
  logic        r_fresh;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_dma_rdata;
  logic [7:0]  r_stall_cnt;

  logic        w_in_idle;
  logic        w_in_c_issue;
  logic        w_in_c_done;
  logic        w_in_d_issue;
  logic        w_in_d_done;
  logic        w_arb_slot;
  logic        w_grant_cpu;
  logic        w_grant_dma;
  logic        w_perform;
  logic        w_stall_inc;

  assign w_in_idle    = (r_state == c_IDLE);
  assign w_in_c_issue = (r_state == c_C_ISSUE);
  assign w_in_c_done  = (r_state == c_C_DONE);
  assign w_in_d_issue = (r_state == c_D_ISSUE);
  assign w_in_d_done  = (r_state == c_D_DONE);
  assign w_arb_slot   = w_in_idle | w_in_c_done | w_in_d_done;

  // Until something has been served the pointer carries no history, so the
  // CPU wins the very first tie; afterwards the side not served last wins.
  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_dma = 1'b0;
    if (w_arb_slot) begin
      if (CpuReq && DmaReq) begin
        if (r_fresh || r_last_dma) begin
          w_grant_cpu = 1'b1;
        end else begin
          w_grant_dma = 1'b1;
        end
      end else if (CpuReq) begin
        w_grant_cpu = 1'b1;
      end else if (DmaReq) begin
        w_grant_dma = 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = c_IDLE;
    case (r_state)
      c_C_ISSUE: w_next_state = c_C_DONE;
      c_D_ISSUE: w_next_state = c_D_DONE;
      default: begin
        if (w_grant_cpu) begin
          w_next_state = c_C_ISSUE;
        end else if (w_grant_dma) begin
          w_next_state = c_D_ISSUE;
        end else begin
          w_next_state = c_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    MemAddr  = 16'h0000;
    MemWData = 16'h0000;
    MemWE    = 1'b0;
    if (w_in_c_issue) begin
      MemAddr  = CpuAddr;
      MemWData = CpuWData;
      MemWE    = CpuWE;
    end else if (w_in_d_issue) begin
      MemAddr  = DmaAddr;
      MemWData = DmaWData;
      MemWE    = DmaWE;
    end
  end

  assign w_perform = ~CpuReq | w_in_c_done;
  // The IDLE cycle in which a request is first seen is the arbitration slot,
  // not contention, so only stalls past that point are counted.
  assign w_stall_inc = ~w_perform & ~w_in_idle & (r_stall_cnt != c_STALL_MAX);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= c_IDLE;
      r_last_dma  <= 1'b0;
      r_fresh     <= 1'b1;
      r_cpu_rdata <= 16'h0000;
      r_dma_rdata <= 16'h0000;
      r_stall_cnt <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (w_grant_dma) begin
        r_last_dma <= 1'b1;
        r_fresh    <= 1'b0;
      end else if (w_grant_cpu) begin
        r_last_dma <= 1'b0;
        r_fresh    <= 1'b0;
      end
      if (w_in_c_done) begin
        r_cpu_rdata <= MemRData;
      end
      if (w_in_d_done) begin
        r_dma_rdata <= MemRData;
      end
      if (w_stall_inc) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
    end
  end

  assign Perform  = w_perform;
  assign DmaAck   = w_in_d_done;
  assign CpuRData = r_cpu_rdata;
  assign DmaRData = r_dma_rdata;
  assign StallCnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a synchronous memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [1:0] K_CPU_RD = 2'd0;
  localparam logic [1:0] K_DMA_RD = 2'd1;
  localparam logic [1:0] K_MEM_WR = 2'd2;
  localparam logic [1:0] K_GRANT  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        CpuReq = 1'b0;
  logic        CpuWE = 1'b0;
  logic [15:0] CpuAddr = 16'h0000;
  logic [15:0] CpuWData = 16'h0000;
  logic [15:0] CpuRData;
  logic        Perform;
  logic        DmaReq = 1'b0;
  logic        DmaWE = 1'b0;
  logic [15:0] DmaAddr = 16'h0000;
  logic [15:0] DmaWData = 16'h0000;
  logic [15:0] DmaRData;
  logic        DmaAck;
  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemWE;
  logic [15:0] MemRData;
  logic [7:0]  StallCnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t e;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .CpuReq(CpuReq), .CpuWE(CpuWE), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuRData(CpuRData), .Perform(Perform),
    .DmaReq(DmaReq), .DmaWE(DmaWE), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
    .DmaRData(DmaRData), .DmaAck(DmaAck),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRData(MemRData),
    .StallCnt(StallCnt)
  );

  // Synchronous single-port memory with a bench-side preload port.
  logic [15:0] mem [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'h0000;
  logic [15:0] bd_data = 16'h0000;

  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MemWE) mem[MemAddr] <= MemWData;
    MemRData <= mem[MemAddr];
  end

  int wr_pulses = 0;
  int ack_pulses = 0;
  always @(negedge CLK) begin
    if (MemWE === 1'b1) wr_pulses++;
    if (DmaAck === 1'b1) ack_pulses++;
  end

  task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge CLK);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RESET = 1'b0; CpuReq = 1'b0; DmaReq = 1'b0; CpuWE = 1'b0; DmaWE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    bd_write(16'h0010, 16'hBEEF);
    bd_write(16'h0011, 16'hCAFE);
    bd_write(16'h0030, 16'hAAAA);
    @(negedge CLK);
    checks++; if (MemWE !== 1'b0) begin errors++; $display("FAIL rst_memwe: got %b want 0", MemWE); end
    checks++; if (DmaAck !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", DmaAck); end
    checks++; if (StallCnt !== 8'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", StallCnt); end
    checks++; if (CpuRData !== 16'h0000) begin errors++; $display("FAIL rst_cpurdata: got %h want 0000", CpuRData); end
    checks++; if (DmaRData !== 16'h0000) begin errors++; $display("FAIL rst_dmardata: got %h want 0000", DmaRData); end
    checks++; if (Perform !== 1'b1) begin errors++; $display("FAIL rst_perform_idle: got %b want 1", Perform); end
    CpuReq = 1'b1;
    #1;
    checks++; if (Perform !== 1'b0) begin errors++; $display("FAIL rst_perform_req: got %b want 0", Perform); end
    @(negedge CLK);
    checks++; if (StallCnt !== 8'd0) begin errors++; $display("FAIL rst_stall_held: got %0d want 0", StallCnt); end
    CpuReq = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(posedge CLK); #1;
    CpuAddr = 16'h0010; CpuWE = 1'b0; CpuReq = 1'b1;
    sb_q.push_back('{kind: K_CPU_RD, addr: 16'h0010, data: 16'hBEEF});
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (Perform !== 1'b0) begin errors++; $display("FAIL cpu_issue_perform: got %b want 0", Perform); end
    checks++; if (MemAddr !== 16'h0010 || MemWE !== 1'b0) begin errors++; $display("FAIL cpu_issue_bus: got addr %h we %b want 0010 0", MemAddr, MemWE); end
    @(negedge CLK);
    checks++; if (Perform !== 1'b1) begin errors++; $display("FAIL cpu_done_perform: got %b want 1", Perform); end
    CpuReq = 1'b0;
    @(negedge CLK);
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL cpu_rdata: scoreboard empty"); end
    else begin
      e = sb_q.pop_front();
      if (CpuRData !== e.data) begin errors++; $display("FAIL cpu_rdata: got %h want %h", CpuRData, e.data); end
    end
    checks++; if (StallCnt !== 8'd1) begin errors++; $display("FAIL cpu_stallcnt: got %0d want 1", StallCnt); end
  endtask

  task automatic test_dma_write();
    int  wr0, ack0;
    bit  ok;
    @(posedge CLK); #1;
    DmaAddr = 16'h0020; DmaWData = 16'h1234; DmaWE = 1'b1; DmaReq = 1'b1;
    sb_q.push_back('{kind: K_MEM_WR, addr: 16'h0020, data: 16'h1234});
    wr0 = wr_pulses; ack0 = ack_pulses;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    e = sb_q.pop_front();
    if (MemWE !== 1'b1 || MemAddr !== e.addr || MemWData !== e.data) begin
      errors++; $display("FAIL dma_wr_bus: got we %b addr %h data %h want 1 %h %h", MemWE, MemAddr, MemWData, e.addr, e.data);
    end
    checks++; if (DmaAck !== 1'b0) begin errors++; $display("FAIL dma_ack_early: got %b want 0", DmaAck); end
    @(negedge CLK);
    checks++; if (DmaAck !== 1'b1 || MemWE !== 1'b0) begin errors++; $display("FAIL dma_done: got ack %b we %b want 1 0", DmaAck, MemWE); end
    DmaReq = 1'b0; DmaWE = 1'b0;
    @(negedge CLK);
    checks++; if (wr_pulses - wr0 != 1) begin errors++; $display("FAIL dma_wr_pulses: got %0d want 1", wr_pulses - wr0); end
    checks++; if (ack_pulses - ack0 != 1) begin errors++; $display("FAIL dma_ack_pulses: got %0d want 1", ack_pulses - ack0); end
    // Read back through the CPU port.
    @(posedge CLK); #1;
    CpuAddr = 16'h0020; CpuWE = 1'b0; CpuReq = 1'b1;
    sb_q.push_back('{kind: K_CPU_RD, addr: 16'h0020, data: 16'h1234});
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      if (Perform === 1'b1) ok = 1'b1;
    end
    CpuReq = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL dma_readback_timeout: got no C_DONE want one"); end
    @(negedge CLK);
    checks++;
    e = sb_q.pop_front();
    if (CpuRData !== e.data) begin errors++; $display("FAIL dma_readback: got %h want %h", CpuRData, e.data); end
  endtask

  task automatic test_back_to_back();
    int          last_issue, zero_run, done_seen;
    logic [15:0] who;
    apply_reset();
    @(posedge CLK); #1;
    CpuAddr = 16'h0010; CpuWE = 1'b0; DmaAddr = 16'h0011; DmaWE = 1'b0;
    CpuReq = 1'b1; DmaReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{kind: K_GRANT, addr: 16'h0010, data: 16'd0});
      sb_q.push_back('{kind: K_GRANT, addr: 16'h0011, data: 16'd1});
    end
    sb_q.push_back('{kind: K_CPU_RD, addr: 16'h0010, data: 16'hBEEF});
    sb_q.push_back('{kind: K_DMA_RD, addr: 16'h0011, data: 16'hCAFE});
    last_issue = -1; zero_run = 0; done_seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLK);
      if (MemAddr !== 16'h0000) begin
        who = (MemAddr == 16'h0011) ? 16'd1 : 16'd0;
        checks++;
        if (sb_q.size() == 0 || sb_q[0].kind != K_GRANT) begin
          errors++; $display("FAIL b2b_grant: got extra grant to %0d at cycle %0d want none", who, cyc);
        end else begin
          e = sb_q.pop_front();
          if (who !== e.data) begin errors++; $display("FAIL b2b_grant: got %0d want %0d at cycle %0d", who, e.data, cyc); end
        end
        if (last_issue >= 0) begin
          checks++;
          if (cyc - last_issue != 2) begin errors++; $display("FAIL b2b_gap: got %0d want 2 cycles", cyc - last_issue); end
        end
        last_issue = cyc;
      end
      if (Perform === 1'b1) begin
        if (done_seen > 0) begin
          checks++;
          if (zero_run != 3) begin errors++; $display("FAIL b2b_stall_run: got %0d want 3", zero_run); end
        end
        done_seen++;
        zero_run = 0;
      end else begin
        zero_run++;
      end
    end
    CpuReq = 1'b0; DmaReq = 1'b0;
    checks++;
    if (sb_q.size() == 0 || sb_q[0].kind == K_GRANT) begin
      errors++; $display("FAIL b2b_missing_grants: got %0d queued want 2", sb_q.size());
      while (sb_q.size() > 0 && sb_q[0].kind == K_GRANT) void'(sb_q.pop_front());
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    e = sb_q.pop_front();
    if (CpuRData !== e.data) begin errors++; $display("FAIL b2b_cpu_rdata: got %h want %h", CpuRData, e.data); end
    checks++;
    e = sb_q.pop_front();
    if (DmaRData !== e.data) begin errors++; $display("FAIL b2b_dma_rdata: got %h want %h", DmaRData, e.data); end
  endtask

  task automatic test_stall_saturation();
    logic [7:0] prev;
    bit         wrapped;
    @(posedge CLK); #1;
    CpuAddr = 16'h0010; CpuWE = 1'b0; DmaAddr = 16'h0011; DmaWE = 1'b0;
    CpuReq = 1'b1; DmaReq = 1'b1;
    prev = StallCnt;
    wrapped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (StallCnt < prev) wrapped = 1'b1;
      prev = StallCnt;
    end
    checks++; if (wrapped) begin errors++; $display("FAIL stall_wrap: got a decrease want monotonic"); end
    checks++; if (StallCnt !== 8'd255) begin errors++; $display("FAIL stall_sat: got %0d want 255", StallCnt); end
    CpuReq = 1'b0; DmaReq = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_access();
    int wr0, ack0;
    @(posedge CLK); #1;
    DmaAddr = 16'h0030; DmaWData = 16'h5555; DmaWE = 1'b1; DmaReq = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (MemWE !== 1'b1 || MemAddr !== 16'h0030) begin errors++; $display("FAIL rma_issue: got we %b addr %h want 1 0030", MemWE, MemAddr); end
    #1;
    RESET = 1'b0;
    #1;
    checks++; if (DmaAck !== 1'b0 || MemWE !== 1'b0) begin errors++; $display("FAIL rma_async: got ack %b we %b want 0 0", DmaAck, MemWE); end
    checks++; if (MemAddr !== 16'h0000) begin errors++; $display("FAIL rma_addr: got %h want 0000", MemAddr); end
    checks++; if (StallCnt !== 8'd0) begin errors++; $display("FAIL rma_stall: got %0d want 0", StallCnt); end
    checks++; if (Perform !== 1'b1) begin errors++; $display("FAIL rma_perform: got %b want 1", Perform); end
    DmaReq = 1'b0; DmaWE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    wr0 = wr_pulses; ack0 = ack_pulses;
    repeat (6) @(negedge CLK);
    checks++; if (ack_pulses != ack0) begin errors++; $display("FAIL rma_late_ack: got %0d acks want 0", ack_pulses - ack0); end
    checks++; if (wr_pulses != wr0) begin errors++; $display("FAIL rma_late_write: got %0d writes want 0", wr_pulses - wr0); end
    checks++; if (mem[16'h0030] !== 16'hAAAA) begin errors++; $display("FAIL rma_mem: got %h want aaaa", mem[16'h0030]); end
  endtask

  task automatic test_addr_change();
    bit ok, bus_quiet;
    @(posedge CLK); #1;
    CpuAddr = 16'h0010; CpuWE = 1'b0; CpuReq = 1'b1;
    sb_q.push_back('{kind: K_CPU_RD, addr: 16'h0010, data: 16'hBEEF});
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      if (Perform === 1'b1) ok = 1'b1;
    end
    CpuAddr = 16'h0011; CpuReq = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL addr_timeout: got no C_DONE want one"); end
    @(negedge CLK);
    checks++;
    e = sb_q.pop_front();
    if (CpuRData !== e.data) begin errors++; $display("FAIL addr_change_rdata: got %h want %h", CpuRData, e.data); end
    bus_quiet = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (MemAddr !== 16'h0000 || MemWE !== 1'b0 || Perform !== 1'b1) bus_quiet = 1'b0;
    end
    checks++; if (!bus_quiet) begin errors++; $display("FAIL addr_regrant: got bus activity want idle"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_stall_saturation();
    test_reset_mid_access();
    test_addr_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide ports: CLK  in  1  system clock, rising-edge active.
REQ-002 SHALL provide RESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide CpuReq  in  1  CPU memory access request, held until the access completes.
REQ-004 SHALL provide CpuWE  in  1  CPU write (1) / read (0).
REQ-005 SHALL provide CpuAddr  in  16, CpuWData  in  16  CPU address and write data.
REQ-006 SHALL provide CpuRData  out  16  CPU read data.
REQ-007 SHALL provide Perform  out  1  CPU advance enable; 0 stalls the control unit.
REQ-008 SHALL provide DmaReq  in  1, DmaWE  in  1, DmaAddr  in  16, DmaWData  in  16  DMA request, write enable, address and write data.
REQ-009 SHALL provide DmaRData  out  16, DmaAck  out  1  DMA read data and one-cycle completion pulse.
REQ-010 SHALL provide MemAddr  out  16, MemWData  out  16, MemWE  out  1, MemRData  in  16  single-port synchronous memory (read data valid one cycle after address).
REQ-011 SHALL provide StallCnt  out  8  saturating count of CPU stall cycles.

Function
REQ-012 SHALL implement the states IDLE, C_ISSUE, C_DONE, D_ISSUE and D_DONE, one-hot encoded.
REQ-013 SHALL arbitrate in IDLE, C_DONE and D_DONE. Arbitration rules:
  - only one requester: grant it;
  - both requesting: grant the requester not served last (round-robin pointer LastDma);
  - neither requesting: go to IDLE.
REQ-014 SHALL move from C_ISSUE to C_DONE and from D_ISSUE to D_DONE unconditionally.
REQ-015 SHALL, in C_ISSUE, drive MemAddr=CpuAddr, MemWData=CpuWData and MemWE=CpuWE.
REQ-016 SHALL, in D_ISSUE, drive MemAddr=DmaAddr, MemWData=DmaWData and MemWE=DmaWE.
REQ-017 SHALL, in every other state, drive MemWE=0 and MemAddr/MemWData=0.
REQ-018 SHALL assert MemWE for exactly one cycle per granted write.
REQ-019 SHALL register CpuRData from MemRData in C_DONE and hold it until the next C_DONE.
REQ-020 SHALL register DmaRData from MemRData in D_DONE and hold it likewise.
REQ-021 SHALL assert DmaAck combinationally for exactly one cycle, in D_DONE.
REQ-022 SHALL drive Perform = ~CpuReq | C_DONE (combinational); CPU access latency is 2 cycles with no contention.
REQ-023 SHALL set LastDma=1 on entering D_ISSUE and LastDma=0 on entering C_ISSUE.
REQ-024 SHALL allow back-to-back grants: a DONE state transitions directly to an ISSUE state with no IDLE bubble.
REQ-025 SHALL bound a requester's worst-case wait to one full access of the other requester (4 cycles including its own access).
REQ-026 SHALL increment StallCnt on each cycle where Perform=0, saturating at 255 with no wrap.
REQ-027 SHALL ignore request or address changes during ISSUE/DONE; the access in flight completes using ISSUE-cycle values.
REQ-028 SHALL treat a request deasserted in its DONE cycle as complete, with no further grant.

Reset
REQ-029 SHALL, on RESET=0 and regardless of CLK, immediately force:
  - state=IDLE, LastDma=0, StallCnt=0;
  - CpuRData=0, DmaRData=0;
  - so that outputs are MemWE=0, DmaAck=0, Perform=~CpuReq.
REQ-030 SHALL abandon any in-flight access when reset is asserted mid-access, with no ack and no write after reset release.
REQ-031 SHALL begin arbitration on the first rising CLK edge after RESET returns to 1.

Verification
REQ-032 Bench SHALL cover the CPU read alone: CpuReq=1, CpuAddr=0x0010, mem[0x10]=0xBEEF. Required response:
  - Perform=0 for 1 cycle, then 1 in C_DONE;
  - CpuRData=0xBEEF;
  - StallCnt=1.
REQ-033 Bench SHALL cover the DMA write alone: DmaReq=1, DmaWE=1, DmaAddr=0x0020, DmaWData=0x1234. Required response:
  - MemWE=1 for exactly one cycle with MemAddr=0x0020;
  - DmaAck pulses in the following cycle;
  - a subsequent read of 0x0020 returns 0x1234.
REQ-034 Bench SHALL cover simultaneous requests after reset: CpuReq=DmaReq=1, both held. Required response:
  - grant order is CPU, DMA, CPU, DMA...;
  - no idle cycle between grants;
  - Perform=0 for 3 cycles on each CPU access after the first.
REQ-035 Bench SHALL cover StallCnt saturation: CpuReq=1 with DmaReq continuously held for 600 cycles. Required response: StallCnt=255 with no wrap.
REQ-036 Bench SHALL cover reset mid-access: RESET=0 asserted during D_ISSUE of a write. Required response:
  - state=IDLE, DmaAck=0 and StallCnt=0 immediately;
  - no DmaAck after release.
REQ-037 Bench SHALL cover address change mid-access: CpuAddr changed from 0x0010 to 0x0011 during C_DONE. Required response: CpuRData returns mem[0x0010].
